// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK bank arbiter: JK command codes, FSM state
// encoding and the JK next-state helper.
package jk_bank_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_APPLY = 2'd2
  } arb_state_e;

  function automatic logic jk_next(input logic q_cur, input logic [1:0] code);
    logic nxt;
    case (code)
      JK_HOLD: nxt = q_cur;
      JK_CLR:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~q_cur;
      default: nxt = q_cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with enable, asynchronous active-high reset and
// complementary outputs.
module jk_cell
  import jk_bank_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] jk_i,
  output logic       q_o,
  output logic       qbar_o
);

  logic q_q;
  logic q_d;

  // Next state: apply the JK code only when this cell is selected.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = jk_next(q_q, jk_i);
    end else begin
      q_d = q_q;
    end
  end

  // Cell state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o    = q_q;
  assign qbar_o = ~q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters JK operations on a shared bank
// of WIDTH jk_cell flops. Define JKARB_LOCK_EN to add the lock input.
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       cmd,
  input  logic [IW*NREQ-1:0]      idx,
`ifdef JKARB_LOCK_EN
  input  logic [NREQ-1:0]         lock,
`endif
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qbar
);

  localparam int NW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [NW-1:0]   ptr_q, ptr_d;
  logic [NW-1:0]   gnt_q, gnt_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            found_s;
  logic [NW-1:0]   win_s;
  logic [NW-1:0]   cand_s;
  logic [WIDTH-1:0] cell_en_s;

  function automatic logic [NW-1:0] rr_pos(input logic [NW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end else begin
      sum = sum;
    end
    return NW'(sum);
  endfunction

  // Round-robin search: first active request at or above ptr, with wrap.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = rr_pos(ptr_q, i);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // FSM next state, operation latch and pointer update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (found_s) begin
          gnt_d        = win_s;
          cmd_d        = cmd[2*win_s +: 2];
          idx_d        = idx[IW*win_s +: IW];
          ack_d[win_s] = 1'b1;
          state_d      = ST_APPLY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
`ifdef JKARB_LOCK_EN
        // A locked winner restarts the next search at itself.
        if (lock[gnt_q] && req[gnt_q]) begin
          ptr_d = gnt_q;
        end else begin
          ptr_d = rr_pos(gnt_q, 1);
        end
`else
        ptr_d = rr_pos(gnt_q, 1);
`endif
        if (|req) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cmd_q   <= JK_HOLD;
      idx_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
    end
  end

  // Only the latched target cell is enabled, and only during APPLY.
  always_comb begin
    cell_en_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cell_en_s[i] = (state_q == ST_APPLY) && (int'(idx_q) == i);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk    (clk),
      .reset  (reset),
      .en_i   (cell_en_s[g]),
      .jk_i   (cmd_q),
      .q_o    (q[g]),
      .qbar_o (qbar[g])
    );
  end

  assign ack    = ack_q;
  assign gnt_id = gnt_q;
  assign busy   = (state_q != ST_IDLE);

endmodule
